alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised ALU decode+execute stage for the MIPS pipeline.
//  - Decodes {alu_opcode, alu_funct} into a 4-bit ALU control code.
//  - Executes on DATA_W-bit operands and returns a registered result over valid/ready.
//  - Sits between ID/EX register and EX/MEM; multi-cycle multiply stalls upstream via in_ready.
// PARAMETERS
//  DATA_W   32              operand/result width (>=8, power of 2)
//  SHAMT_W  $clog2(DATA_W)  shift-amount width (localparam, derived)
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        async active-low reset
//  flush       in   1        sync abort: drop in-flight op and pending result
//  in_valid    in   1        operation offered
//  in_ready    out  1        operation accepted when in_valid&&in_ready
//  alu_opcode  in   2        11 ADD, 10 SLT, 01 SUB, 00 use alu_funct
//  alu_funct   in   4        function field (decode table below)
//  op_a        in   DATA_W   operand A
//  op_b        in   DATA_W   operand B
//  shamt       in   SHAMT_W  shift amount
//  out_valid   out  1        result held until out_ready
//  out_ready   in   1        downstream accepts result
//  result      out  DATA_W   result
//  zero        out  1        result==0
//  alu_ctrl    out  4        decoded control of the held result
//  illegal     out  1        held result came from an undefined funct
// BEHAVIOUR
//  Decode (opcode 00): 0000 ADD(0), 0001 SUB(1), 0010 AND(2), 0011 OR(3), 0100 SLT(4),
//    0101 XOR(5), 0110 NOR(6), 0111 SLL(7), 1000 SRL(8), 1001 SRA(9), 1010 MUL(10).
//    Opcode 11->ADD, 10->SLT, 01->SUB; alu_funct ignored.
//  Undefined funct: ctrl=ADD code 0, result=0, illegal=1; completes as single-cycle.
//  Arithmetic:
//    - ADD/SUB wrap modulo 2^DATA_W, no overflow flag.
//    - SLT is signed; result 1 or 0, zero-extended.
//    - Shifts use shamt; SRA sign-fills.
//    - MUL returns low DATA_W bits of the unsigned product.
//  FSM states IDLE, MUL, HOLD.
//    IDLE: in_ready=1 when !out_valid || out_ready (bubble-free pass-through).
//      Accept single-cycle op -> registered result; out_valid=1 next cycle (latency 1).
//      Accept MUL -> MUL; latch operands; cnt=0.
//    MUL: shift-add, one bit per cycle; in_ready=0.
//      After DATA_W cycles result loads; out_valid=1 -> HOLD.
//      Total latency DATA_W+1 from accept.
//    HOLD: out_valid=1, in_ready=0; on out_ready -> IDLE, out_valid=0 the next cycle.
//  Output stability: result/zero/alu_ctrl/illegal stable while out_valid && !out_ready.
//  Back-to-back: IDLE with out_valid&&out_ready&&in_valid retires old, loads new same edge.
//  flush (priority over all else):
//    - next cycle state=IDLE, out_valid=0, cnt=0;
//    - any op offered that cycle is not accepted (in_ready forced 0).
//  Reset (async, rst_n=0): state IDLE, out_valid=0, result=0, zero=1, alu_ctrl=0, illegal=0, cnt=0.
//    Reset mid-MUL discards the operation with no output.
//  in_ready is combinational from state/out_valid/out_ready/flush only; never from in_valid.
// CONFIGURATION
//  ALU_MUL_EN defined:
//    - MUL (funct 1010) is legal and uses the MUL state as above.
//  ALU_MUL_EN undefined:
//    - no multiplier, no MUL state, no cnt register;
//    - funct 1010 decodes as undefined (result 0, illegal=1, latency 1).
// TESTING
//  1 Reset: rst_n=0 mid-stream -> out_valid=0, result=0, zero=1, in_ready=1 after release.
//  2 opcode=00 funct=0001 A=5 B=7 -> next cycle result=32'hFFFFFFFE, alu_ctrl=1, zero=0.
//  3 opcode=10 A=32'hFFFFFFFF B=1 -> result=1 (signed SLT).
//    Then funct=1001 A=32'h80000000 shamt=4 -> result=32'hF8000000.
//  4 out_ready=0 three cycles after ADD 3+4 -> result=7 held, in_ready=0.
//    Raise out_ready with next op in_valid -> new result the following cycle, no bubble.
//  5 ALU_MUL_EN: MUL A=6 B=7 -> in_ready=0 for DATA_W cycles; out_valid at cycle 33; result=42.
//    flush at cycle 10 -> out_valid never asserts.
//  6 funct=1111 (and 1010 without ALU_MUL_EN) -> illegal=1, result=0, zero=1, latency 1.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ALU decode + execute stage with a registered valid/ready result port.
// Define ALU_MUL_EN to enable the multi-cycle shift-add multiplier (funct 1010).
module alu_exec_unit #(
   parameter  int unsigned DATA_W  = 32,
   localparam int unsigned SHAMT_W = $clog2(DATA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         alu_opcode,
   input  logic [3:0]         alu_funct,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               zero,
   output logic [3:0]         alu_ctrl,
   output logic               illegal
);

   localparam logic [3:0] CTRL_ADD = 4'd0;
   localparam logic [3:0] CTRL_SUB = 4'd1;
   localparam logic [3:0] CTRL_AND = 4'd2;
   localparam logic [3:0] CTRL_OR  = 4'd3;
   localparam logic [3:0] CTRL_SLT = 4'd4;
   localparam logic [3:0] CTRL_XOR = 4'd5;
   localparam logic [3:0] CTRL_NOR = 4'd6;
   localparam logic [3:0] CTRL_SLL = 4'd7;
   localparam logic [3:0] CTRL_SRL = 4'd8;
   localparam logic [3:0] CTRL_SRA = 4'd9;
`ifdef ALU_MUL_EN
   localparam logic [3:0] CTRL_MUL = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_e;
`else
   typedef enum logic {S_IDLE, S_HOLD} state_e;
`endif

   state_e              state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                zero_q, zero_d;
   logic [3:0]          ctrl_q, ctrl_d;
   logic                illegal_q, illegal_d;
   logic [3:0]          dec_ctrl;
   logic                dec_legal;
   logic [DATA_W-1:0]   exec_res;
`ifdef ALU_MUL_EN
   logic [SHAMT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
`endif

   // Decode {opcode, funct}; undefined functs fall back to ADD code, flagged illegal
   always_comb begin
      dec_ctrl  = CTRL_ADD;
      dec_legal = 1'b1;
      case (alu_opcode)
         2'b11:   dec_ctrl = CTRL_ADD;
         2'b10:   dec_ctrl = CTRL_SLT;
         2'b01:   dec_ctrl = CTRL_SUB;
         default: begin
            if (alu_funct <= CTRL_SRA) dec_ctrl = alu_funct;
`ifdef ALU_MUL_EN
            else if (alu_funct == CTRL_MUL) dec_ctrl = CTRL_MUL;
`endif
            else dec_legal = 1'b0;
         end
      endcase
   end

   // Single-cycle datapath
   always_comb begin
      exec_res = '0;
      case (dec_ctrl)
         CTRL_ADD: exec_res = op_a + op_b;
         CTRL_SUB: exec_res = op_a - op_b;
         CTRL_AND: exec_res = op_a & op_b;
         CTRL_OR:  exec_res = op_a | op_b;
         CTRL_SLT: exec_res = DATA_W'($signed(op_a) < $signed(op_b));
         CTRL_XOR: exec_res = op_a ^ op_b;
         CTRL_NOR: exec_res = ~(op_a | op_b);
         CTRL_SLL: exec_res = op_a << shamt;
         CTRL_SRL: exec_res = op_a >> shamt;
         CTRL_SRA: exec_res = DATA_W'($signed(op_a) >>> shamt);
         default:  exec_res = '0;
      endcase
      if (!dec_legal) exec_res = '0;
   end

   // Next-state and handshake
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      ctrl_d      = ctrl_q;
      illegal_d   = illegal_q;
      in_ready    = 1'b0;
`ifdef ALU_MUL_EN
      cnt_d       = cnt_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      acc_d       = acc_q;
`endif
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
`ifdef ALU_MUL_EN
         cnt_d       = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               in_ready = !out_valid_q || out_ready;
               if (out_ready) out_valid_d = 1'b0;
               if (in_valid && in_ready) begin
`ifdef ALU_MUL_EN
                  if (dec_ctrl == CTRL_MUL) begin
                     state_d = S_MUL;
                     cnt_d   = '0;
                     mul_a_d = op_a;
                     mul_b_d = op_b;
                     acc_d   = '0;
                  end else
`endif
                  begin
                     out_valid_d = 1'b1;
                     result_d    = exec_res;
                     ctrl_d      = dec_ctrl;
                     illegal_d   = !dec_legal;
                  end
               end
            end
`ifdef ALU_MUL_EN
            // One multiplier bit per cycle; result loads on the last step
            S_MUL: begin
               acc_d   = acc_q + (mul_b_q[0] ? mul_a_q : '0);
               mul_a_d = mul_a_q << 1;
               mul_b_d = mul_b_q >> 1;
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == SHAMT_W'(DATA_W - 1)) begin
                  result_d    = acc_d;
                  ctrl_d      = CTRL_MUL;
                  illegal_d   = 1'b0;
                  out_valid_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = S_HOLD;
               end
            end
`endif
            S_HOLD: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b1;
         ctrl_q      <= CTRL_ADD;
         illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
         cnt_q       <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         acc_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ctrl_q      <= ctrl_d;
         illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
         cnt_q       <= cnt_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         acc_q       <= acc_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign alu_ctrl  = ctrl_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (DATA_W=32); MUL steps run only with ALU_MUL_EN.
module tb_alu_exec_unit;

   logic        clk, rst_n, flush, in_valid, in_ready;
   logic [1:0]  alu_opcode;
   logic [3:0]  alu_funct;
   logic [31:0] op_a, op_b, result;
   logic [4:0]  shamt;
   logic        out_valid, out_ready, zero, illegal;
   logic [3:0]  alu_ctrl;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_opcode(alu_opcode), .alu_funct(alu_funct), .op_a(op_a), .op_b(op_b),
      .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero(zero), .alu_ctrl(alu_ctrl), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  opc;
      logic [3:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic [3:0]  ctrl;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] opc, input logic [3:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      alu_opcode = opc; alu_funct = fn; op_a = a; op_b = b; shamt = sh;
   endtask

   initial begin
      vecs = '{
         '{2'b11, 4'b1111, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        4'd0},
         '{2'b01, 4'b0000, 32'd10,       32'd3,        5'd0,  32'd7,        4'd1},
         '{2'b00, 4'b0010, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 4'd2},
         '{2'b00, 4'b0011, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 4'd3},
         '{2'b00, 4'b0100, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        4'd4},
         '{2'b00, 4'b0101, 32'h000000A5, 32'h000000FF, 5'd0,  32'h0000005A, 4'd5},
         '{2'b00, 4'b0110, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 4'd6},
         '{2'b00, 4'b0111, 32'h1,        32'h0,        5'd31, 32'h80000000, 4'd7},
         '{2'b00, 4'b1000, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 4'd8},
         '{2'b00, 4'b0000, 32'd100,      32'd23,       5'd0,  32'd123,      4'd0}
      };

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      drive(2'b00, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick(); tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_zero", 32'(zero), 32'd1);
      check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // SUB 5-7 wraps
      in_valid = 1'b1;
      drive(2'b00, 4'b0001, 32'd5, 32'd7, 5'd0);
      tick();
      check("sub_valid", 32'(out_valid), 32'd1);
      check("sub_result", result, 32'hFFFFFFFE);
      check("sub_ctrl", 32'(alu_ctrl), 32'd1);
      check("sub_zero", 32'(zero), 32'd0);

      // Signed SLT, then SRA sign fill
      drive(2'b10, 4'b0000, 32'hFFFFFFFF, 32'd1, 5'd0);
      tick();
      check("slt_result", result, 32'd1);
      check("slt_ctrl", 32'(alu_ctrl), 32'd4);
      drive(2'b00, 4'b1001, 32'h80000000, 32'd0, 5'd4);
      tick();
      check("sra_result", result, 32'hF8000000);
      check("sra_ctrl", 32'(alu_ctrl), 32'd9);

      foreach (vecs[i]) begin
         drive(vecs[i].opc, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].sh);
         tick();
         check($sformatf("vec%0d_result", i), result, vecs[i].res);
         check($sformatf("vec%0d_ctrl", i), 32'(alu_ctrl), 32'(vecs[i].ctrl));
         check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].res == 32'h0));
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      end

      in_valid = 1'b0;
      tick();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Backpressure: ADD 3+4 held while a SUB waits
      in_valid = 1'b1; out_ready = 1'b0;
      drive(2'b11, 4'b0000, 32'd3, 32'd4, 5'd0);
      tick();
      drive(2'b01, 4'b0000, 32'd10, 32'd1, 5'd0);
      for (int c = 0; c < 3; c++) begin
         check("hold_result", result, 32'd7);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      check("hold_result_end", result, 32'd7);
      out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("b2b_result", result, 32'd9);
      check("b2b_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      tick();
      check("b2b_retire", 32'(out_valid), 32'd0);

      // Undefined funct
      in_valid = 1'b1;
      drive(2'b00, 4'b1111, 32'd5, 32'd5, 5'd0);
      tick();
      check("ill_valid", 32'(out_valid), 32'd1);
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_result", result, 32'h0);
      check("ill_zero", 32'(zero), 32'd1);
      check("ill_ctrl", 32'(alu_ctrl), 32'd0);
`ifndef ALU_MUL_EN
      drive(2'b00, 4'b1010, 32'd6, 32'd7, 5'd0);
      tick();
      check("mulx_flag", 32'(illegal), 32'd1);
      check("mulx_result", result, 32'h0);
      check("mulx_valid", 32'(out_valid), 32'd1);
`endif
      drive(2'b11, 4'b0000, 32'd1, 32'd1, 5'd0);
      tick();
      check("legal_after_ill", 32'(illegal), 32'd0);
      check("legal_after_ill_res", result, 32'd2);

      // flush blocks acceptance and drops the pending result
      flush = 1'b1;
      drive(2'b11, 4'b0000, 32'd8, 32'd8, 5'd0);
      #1;
      check("flush_in_ready", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_result", result, 32'd2);
      out_ready = 1'b0;
      tick();
      check("pend_valid", 32'(out_valid), 32'd1);
      check("pend_result", result, 32'd16);
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b1;
      check("pend_flushed", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
      // MUL 6*7: out_valid 33 cycles after accept
      in_valid = 1'b1;
      drive(2'b00, 4'b1010, 32'd6, 32'd7, 5'd0);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 31; c++) begin
         check("mul_busy_ready", 32'(in_ready), 32'd0);
         check("mul_busy_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("mul_last_ready", 32'(in_ready), 32'd0);
      tick();
      check("mul_valid", 32'(out_valid), 32'd1);
      check("mul_result", result, 32'd42);
      check("mul_ctrl", 32'(alu_ctrl), 32'd10);
      check("mul_illegal", 32'(illegal), 32'd0);
      tick();
      check("mul_retire", 32'(out_valid), 32'd0);

      // MUL aborted by flush mid-operation
      in_valid = 1'b1;
      drive(2'b00, 4'b1010, 32'd6, 32'd7, 5'd0);
      tick();
      in_valid = 1'b0;
      for (int c = 1; c < 10; c++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int c = 0; c < 40; c++) begin
         check("mulflush_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check("mulflush_in_ready", 32'(in_ready), 32'd1);
`endif

      // Asynchronous reset in the middle of a stream
      in_valid = 1'b1;
      drive(2'b11, 4'b0000, 32'd3, 32'd3, 5'd0);
      tick();
      check("pre_rst_result", result, 32'd6);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_result", result, 32'h0);
      check("arst_zero", 32'(zero), 32'd1);
      tick();
      rst_n = 1'b1;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
